// File: rtl/db_tick.sv
// db_tick: switch debouncer with a 2-flop synchronizer, a four-state
// wait/confirm FSM and one-cycle rise/fall ticks on accepted level changes.
module db_tick #(
  parameter int DB_TICKS = 500000,
  parameter int CNT_W    = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic tick_rise,
  output logic tick_fall
);

  // Encoding chosen so bit 1 is the debounced level (ONE and WAIT0 both read 1).
  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] WAIT0 = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_TICKS - 1);

  logic [1:0]       sync_reg;
  logic             sw_s;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             rise_next;
  logic             fall_next;
  logic             rise_reg;
  logic             fall_reg;

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], sw};
    end
  end

  assign sw_s = sync_reg[1];

  // Next-state, counter and tick decode; a reversal during a wait aborts it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
        end else if (cnt_reg == '0) begin
          state_next = ONE;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
        end else if (cnt_reg == '0) begin
          state_next = ZERO;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ZERO;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and tick registers; ticks line up with the level change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign db_level  = state_reg[1];
  assign tick_rise = rise_reg;
  assign tick_fall = fall_reg;

endmodule
